// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// loader_pkg : shared types and constants for the instruction boot loader
// Rev 1.0
// ============================================================================
package loader_pkg;

  localparam int WORD_BYTES          = 4;
  localparam int RELEASE_DLY_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/byte_word_packer.sv
`default_nettype none
// ============================================================================
// byte_word_packer : assembles little-endian words from a byte stream
// Rev 1.0
// ============================================================================
module byte_word_packer
  import loader_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    accept_i,
  input  logic [7:0]              byte_data_i,
  input  logic                    clear_i,
  output logic [8*WORD_BYTES-1:0] word_o,
  output logic                    last_byte_o
);

  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0]        cnt_q;
  logic [8*WORD_BYTES-1:0] word_q;

  // Shifting in from the top leaves the first byte in the LSB after a full word.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (accept_i) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      word_q <= {byte_data_i, word_q[8*WORD_BYTES-1:8]};
    end
  end

  assign word_o      = word_q;
  assign last_byte_o = (cnt_q == CNT_W'(WORD_BYTES - 1));

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// imem_boot_loader : loads a byte stream into instruction memory, then
// releases the core from reset. Rev 1.0
// ============================================================================
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int ADDR_W      = 9,
  parameter int RELEASE_DLY = RELEASE_DLY_DEFAULT
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [7:0]        load_len_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_e              state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          widx_q, widx_d;
  logic [3:0]          dly_q, dly_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [31:0]         mdata_q, mdata_d;

  logic                pk_clear;
  logic                pk_accept;
  logic                pk_last;
  logic [31:0]         pk_word;
  logic                len_ok;
  logic [ADDR_W-1:0]   wr_addr;

  assign pk_accept = byte_valid_i && (state_q == ST_RECV);
  assign len_ok    = (load_len_i != 8'd0) && (32'(load_len_i) <= DEPTH_WORDS);
  assign wr_addr   = ADDR_W'({widx_q, 2'b00});

  byte_word_packer u_packer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .accept_i    (pk_accept),
    .byte_data_i (byte_data_i),
    .clear_i     (pk_clear),
    .word_o      (pk_word),
    .last_byte_o (pk_last)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    widx_d   = widx_q;
    dly_d    = dly_q;
    maddr_d  = maddr_q;
    mdata_d  = mdata_q;
    pk_clear = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start_i) begin
          if (len_ok) begin
            state_d  = ST_RECV;
            len_d    = load_len_i;
            widx_d   = 8'd0;
            pk_clear = 1'b1;
          end else begin
            state_d  = ST_ERR;
          end
        end
      end
      ST_RECV: begin
        if (byte_valid_i && pk_last) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // Capture the port values so they hold once the strobe drops.
        maddr_d = wr_addr;
        mdata_d = pk_word;
        widx_d  = widx_q + 8'd1;
        if (widx_q == len_q - 8'd1) begin
          state_d = ST_HOLD;
          dly_d   = 4'd0;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_HOLD: begin
        if (dly_q == 4'(RELEASE_DLY - 1)) state_d = ST_RUN;
        else                              dly_d   = dly_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      len_q   <= 8'd0;
      widx_q  <= 8'd0;
      dly_q   <= 4'd0;
      maddr_q <= '0;
      mdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      dly_q   <= dly_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
    end
  end

  assign byte_ready_o = (state_q == ST_RECV);
  assign mem_we_o     = (state_q == ST_WRITE);
  assign mem_addr_o   = mem_we_o ? wr_addr : maddr_q;
  assign mem_wdata_o  = mem_we_o ? pk_word : mdata_q;
  assign core_reset_o = (state_q != ST_RUN);
  assign busy_o       = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_HOLD);
  assign done_o       = (state_q == ST_RUN);
  assign err_o        = (state_q == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_boot_loader : directed self-checking bench for imem_boot_loader
// Rev 1.0
// ============================================================================
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  load_len_i = 8'd0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'd0;
  logic        byte_ready_o, mem_we_o, core_reset_o, busy_o, done_o, err_o;
  logic [8:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  logic [8:0]  wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  imem_boot_loader #(.DEPTH_WORDS(128), .ADDR_W(9), .RELEASE_DLY(2)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .load_len_i   (load_len_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .core_reset_o (core_reset_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  // Write log and byte-accept counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we_o) begin
      wa_q.push_back(mem_addr_o);
      wd_q.push_back(mem_wdata_o);
    end
    if (byte_valid_i && byte_ready_o) acc_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] len);
    start_i    = 1'b1;
    load_len_i = len;
    step();
    start_i    = 1'b0;
  endtask

  // Sends one word LSB first; returns in the cycle the DUT shows WRITE.
  task automatic send_word(input logic [31:0] w, input int maxgap);
    int t;
    for (int k = 0; k < 4; k++) begin
      if (maxgap > 0) begin
        byte_valid_i = 1'b0;
        repeat ($urandom_range(maxgap, 0)) step();
      end
      byte_valid_i = 1'b1;
      byte_data_i  = w[8*k +: 8];
      t = 0;
      while (!byte_ready_o && t < 50) begin
        step();
        t++;
      end
      if (t >= 50) chk("handshake_timeout", {31'd0, byte_ready_o}, 32'd1);
      step();
    end
    byte_valid_i = 1'b0;
  endtask

  // Steps from the last WRITE through release: RELEASE_DLY=2.
  task automatic check_release(input string tag);
    step();
    chk({tag, "_w+1_core_reset"}, {31'd0, core_reset_o}, 32'd1);
    step();
    chk({tag, "_w+2_core_reset"}, {31'd0, core_reset_o}, 32'd1);
    step();
    chk({tag, "_w+3_core_reset"}, {31'd0, core_reset_o}, 32'd0);
    chk({tag, "_w+3_done"},       {31'd0, done_o},       32'd1);
  endtask

  initial begin
    int bad;
    logic [31:0] w;

    // Reset state
    step(); step();
    chk("rst_core_reset", {31'd0, core_reset_o}, 32'd1);
    chk("rst_byte_ready", {31'd0, byte_ready_o}, 32'd0);
    chk("rst_mem_we",     {31'd0, mem_we_o},     32'd0);
    chk("rst_busy",       {31'd0, busy_o},       32'd0);
    chk("rst_done",       {31'd0, done_o},       32'd0);
    chk("rst_err",        {31'd0, err_o},        32'd0);
    chk("rst_mem_addr",   {23'd0, mem_addr_o},   32'd0);
    chk("rst_mem_wdata",  mem_wdata_o,           32'd0);
    reset_i = 1'b0;
    step();

    // Nominal two-word load
    wa_q.delete(); wd_q.delete();
    do_start(8'd2);
    chk("nom_byte_ready", {31'd0, byte_ready_o}, 32'd1);
    chk("nom_busy",       {31'd0, busy_o},       32'd1);
    send_word(32'h00500013, 0);
    send_word(32'h00A00093, 0);
    chk("nom_we2",    {31'd0, mem_we_o},   32'd1);
    chk("nom_addr2",  {23'd0, mem_addr_o}, 32'd4);
    chk("nom_data2",  mem_wdata_o,         32'h00A00093);
    check_release("nom");
    chk("nom_hold_addr", {23'd0, mem_addr_o}, 32'd4);
    chk("nom_wr_count",  wa_q.size(),         32'd2);
    chk("nom_addr1",     {23'd0, wa_q[0]},    32'd0);
    chk("nom_data1",     wd_q[0],             32'h00500013);

    // Backpressure: reload from RUN with random gaps
    wa_q.delete(); wd_q.delete(); acc_cnt = 0;
    do_start(8'd2);
    chk("bp_core_reset", {31'd0, core_reset_o}, 32'd1);
    send_word(32'h00500013, 5);
    send_word(32'h00A00093, 5);
    check_release("bp");
    chk("bp_wr_count", wa_q.size(),      32'd2);
    chk("bp_addr1",    {23'd0, wa_q[1]}, 32'd4);
    chk("bp_data0",    wd_q[0],          32'h00500013);
    chk("bp_data1",    wd_q[1],          32'h00A00093);
    chk("bp_accepts",  acc_cnt,          32'd8);

    // Reload from RUN
    wa_q.delete(); wd_q.delete();
    do_start(8'd1);
    chk("rl_core_reset", {31'd0, core_reset_o}, 32'd1);
    chk("rl_done",       {31'd0, done_o},       32'd0);
    send_word(32'hDEADBEEF, 0);
    chk("rl_addr", {23'd0, mem_addr_o}, 32'd0);
    chk("rl_data", mem_wdata_o,         32'hDEADBEEF);
    check_release("rl");

    // Length errors
    wa_q.delete(); wd_q.delete();
    do_start(8'd0);
    chk("len0_err",        {31'd0, err_o},        32'd1);
    chk("len0_core_reset", {31'd0, core_reset_o}, 32'd1);
    chk("len0_done",       {31'd0, done_o},       32'd0);
    do_start(8'd129);
    chk("len129_err",        {31'd0, err_o},        32'd1);
    chk("len129_core_reset", {31'd0, core_reset_o}, 32'd1);
    chk("len129_busy",       {31'd0, busy_o},       32'd0);
    chk("lenerr_no_we",      wa_q.size(),           32'd0);
    do_start(8'd1);
    chk("lenok_err",        {31'd0, err_o},        32'd0);
    chk("lenok_byte_ready", {31'd0, byte_ready_o}, 32'd1);
    send_word(32'h12345678, 0);
    chk("lenok_addr", {23'd0, mem_addr_o}, 32'd0);
    chk("lenok_data", mem_wdata_o,         32'h12345678);
    check_release("lenok");

    // Reset after two bytes of word 1
    do_start(8'd2);
    send_word(32'h11111111, 0);
    byte_valid_i = 1'b1;
    byte_data_i  = 8'hAA;
    step();
    chk("mid_ready_a", {31'd0, byte_ready_o}, 32'd1);
    step();
    byte_data_i = 8'hBB;
    step();
    wa_q.delete(); wd_q.delete();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("mid_core_reset", {31'd0, core_reset_o}, 32'd1);
    chk("mid_busy",       {31'd0, busy_o},       32'd0);
    chk("mid_done",       {31'd0, done_o},       32'd0);
    chk("mid_byte_ready", {31'd0, byte_ready_o}, 32'd0);
    repeat (5) step();
    byte_valid_i = 1'b0;
    chk("mid_no_we", wa_q.size(), 32'd0);
    do_start(8'd1);
    send_word(32'hCAFEF00D, 0);
    chk("fresh_addr", {23'd0, mem_addr_o}, 32'd0);
    chk("fresh_data", mem_wdata_o,         32'hCAFEF00D);
    check_release("fresh");

    // Full depth, with an ignored start during the load
    wa_q.delete(); wd_q.delete();
    do_start(8'd128);
    chk("full_err", {31'd0, err_o}, 32'd0);
    for (int i = 0; i < 128; i++) begin
      w = {8'(i), 8'hC3, ~8'(i), 8'(i)};
      send_word(w, 0);
      if (i == 10) begin
        start_i    = 1'b1;
        load_len_i = 8'd0;
        step();
        start_i    = 1'b0;
        chk("busy_start_err",  {31'd0, err_o},  32'd0);
        chk("busy_start_busy", {31'd0, busy_o}, 32'd1);
      end
    end
    chk("full_last_addr", {23'd0, mem_addr_o}, 32'h1FC);
    chk("full_last_data", mem_wdata_o,         32'h7FC3807F);
    check_release("full");
    chk("full_wr_count", wa_q.size(), 32'd128);
    bad = 0;
    for (int i = 0; i < 128 && i < wa_q.size(); i++) begin
      w = {8'(i), 8'hC3, ~8'(i), 8'(i)};
      if (wa_q[i] !== 9'(4 * i) || wd_q[i] !== w) bad++;
    end
    chk("full_seq_bad", bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
